uart_tx_sched: RTL

Round-robin scheduler that lets several message sources share the single UART transmitter in `uart_top`. It grants one source at a time for a whole message, up to the last byte or a fairness cap, and forwards its bytes through a one-entry output register to the transmitter's byte interface. It enforces a programmable idle gap between messages.

---
 rtl/uart_sched_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and the byte type.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_LOCKED = 2'd1,
    SCHED_GAP    = 2'd2
  } sched_state_e;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after start_i, wrapping modulo N. Generic so other arbiters can reuse it.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    // NOTE: idx_o is assigned before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    idx_o = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(int'(start_i) + off) % N]) begin
        idx_o = IW'((int'(start_i) + off) % N);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_SRC message
// sources. A grant lasts a whole message (or MAX_LEN bytes), bytes pass through
// a one-entry output register, and GAP_CYCLES idle cycles follow every grant.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*8-1:0]         src_data,
  input  logic [NUM_SRC-1:0]           src_last,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         preempt
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IW-1:0] SRC_MAX  = IW'(NUM_SRC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_e  state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tx_valid_q, tx_valid_d;
  byte_t         tx_data_q, tx_data_d;
  logic          preempt_q, preempt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          sel_valid, sel_last, can_load, xfer, grant_end;
  byte_t         sel_data;

  uart_rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req_i   (src_valid),
    .start_i (rr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign sel_valid = src_valid[grant_id_q];
  assign sel_last  = src_last[grant_id_q];
  assign sel_data  = src_data[8*grant_id_q +: 8];

  // The output register can take a byte when empty or draining this cycle.
  assign can_load  = !tx_valid_q || tx_ready;
  assign xfer      = (state_q == SCHED_LOCKED) && sel_valid && can_load;
  assign grant_end = xfer && (sel_last || (cnt_q == CNT_LAST));

  // Only the granted source sees ready, and only while LOCKED.
  always_comb begin
    src_ready = '0;
    if (state_q == SCHED_LOCKED) begin
      src_ready[grant_id_q] = can_load;
    end
  end

  // Arbitration FSM: next state, grant bookkeeping and the preempt pulse.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    preempt_d  = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          cnt_d      = '0;
          state_d    = SCHED_LOCKED;
        end
      end
      SCHED_LOCKED: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (grant_end) begin
          rr_d      = (grant_id_q == SRC_MAX) ? '0 : grant_id_q + 1'b1;
          preempt_d = !sel_last;
          gap_d     = '0;
          state_d   = (GAP_CYCLES > 0) ? SCHED_GAP : SCHED_IDLE;
        end
      end
      SCHED_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SCHED_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // Output register: loads on a transfer, empties on tx_ready otherwise.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (xfer) begin
      tx_valid_d = 1'b1;
      tx_data_d  = sel_data;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // State, counters, pointer and output register, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= SCHED_IDLE;
      rr_q       <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      preempt_q  <= preempt_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign preempt  = preempt_q;
  assign busy     = (state_q != SCHED_IDLE) || tx_valid_q;

endmodule
